// File: rtl/corner_pkg.sv
// Shared types and helpers for the corner-record merger: FSM encoding,
// default record width and the channel-index width computation.
package corner_pkg;

  localparam int REC_W_DEF = 128;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    SERVE = 1'b1
  } state_t;

  // Index width for n channels, never narrower than one bit.
  function automatic int calc_id_w(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans start+1, start+2, ... ending with
// start itself, and reports the first eligible channel.
module rr_pick
  import corner_pkg::*;
#(
  parameter int N    = 2,
  parameter int ID_W = calc_id_w(N)
) (
  input  logic [N-1:0]    elig,
  input  logic [ID_W-1:0] start,
  output logic [ID_W-1:0] idx,
  output logic            found
);

  // Priority scan in rotated order; the first hit wins.
  always_comb begin
    int   ch;
    logic hit;
    idx   = start;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      ch    = (int'(start) + k) % N;
      hit   = !found && elig[ch];
      idx   = hit ? ID_W'(ch) : idx;
      found = found | hit;
    end
  end

endmodule

// File: rtl/corner_merge.sv
// Merges N_CAM show-ahead corner-record FIFOs into one stream with
// round-robin arbitration, bounded bursts and per-channel pop counters.
module corner_merge
  import corner_pkg::*;
#(
  parameter  int N_CAM     = 2,
  parameter  int REC_W     = REC_W_DEF,
  parameter  int MAX_BURST = 4,
  parameter  int CNT_W     = 32,
  localparam int ID_W      = calc_id_w(N_CAM)
) (
  input  logic                   c,
  input  logic                   rst_n,
  input  logic [N_CAM-1:0]       en,
  input  logic [N_CAM*REC_W-1:0] in_q,
  input  logic [N_CAM-1:0]       in_empty,
  output logic [N_CAM-1:0]       in_read,
  output logic [REC_W-1:0]       out_q,
  output logic [ID_W-1:0]        out_cam,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   clr,
  output logic [N_CAM*CNT_W-1:0] count
);

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   grant_nxt;
  logic [7:0]        burst;
  logic [7:0]        burst_nxt;
  logic [7:0]        burst_inc;
  logic              pop;
  logic              load;
  logic [N_CAM-1:0]  elig;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_found;
  logic [REC_W-1:0]  sel_q;
  logic [CNT_W-1:0]  cnt [N_CAM];

  assign elig  = en & ~in_empty;
  assign load  = !out_valid || out_ready;
  assign sel_q = in_q[int'(grant)*REC_W +: REC_W];

  rr_pick #(
    .N    (N_CAM),
    .ID_W (ID_W)
  ) u_pick (
    .elig  (elig),
    .start (grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Arbitration / burst FSM next-state logic.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    burst_nxt = burst;
    burst_inc = burst + 8'd1;
    pop       = 1'b0;
    case (state)
      ARB: begin
        if (pick_found) begin
          grant_nxt = pick_idx;
          burst_nxt = 8'd0;
          state_nxt = SERVE;
        end else begin
          state_nxt = ARB;
        end
      end
      SERVE: begin
        if (!elig[grant]) begin
          state_nxt = ARB;
        end else if (load) begin
          pop       = 1'b1;
          burst_nxt = burst_inc;
          if (burst_inc == 8'(MAX_BURST)) begin
            state_nxt = ARB;
          end else begin
            state_nxt = SERVE;
          end
        end else begin
          state_nxt = SERVE;
        end
      end
      default: begin
        state_nxt = ARB;
      end
    endcase
  end

  // One-hot pop strobe toward the granted FIFO.
  always_comb begin
    in_read = '0;
    if (pop) begin
      in_read[grant] = 1'b1;
    end else begin
      in_read = '0;
    end
  end

  // FSM state, grant pointer and burst length.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB;
      grant <= ID_W'(N_CAM - 1);
      burst <= 8'd0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      burst <= burst_nxt;
    end
  end

  // Output register; holds the record while the consumer stalls.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      out_cam   <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_q     <= sel_q;
      out_cam   <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Per-channel pop counters; clear takes priority over an increment.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CAM; i++) begin
        cnt[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < N_CAM; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CAM; i++) begin
        if (pop && (grant == ID_W'(i))) begin
          cnt[i] <= cnt[i] + CNT_W'(1'b1);
        end
      end
    end
  end

  for (genvar g = 0; g < N_CAM; g++) begin : g_count
    assign count[g*CNT_W +: CNT_W] = cnt[g];
  end

endmodule
